// File: rtl/regfile_read_port.sv
// Read-side controller for a tristate-bus register file: decodes a read request
// into a one-hot out_enable vector, samples the bus and returns the result.
module regfile_read_port #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic [NUM_REGS-1:0] read_enable,
  input  logic [DATA_W-1:0]   bus_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic [ADDR_W-1:0]   resp_addr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W-1:0]   addr_next;
  logic [NUM_REGS-1:0] enable_reg;
  logic [NUM_REGS-1:0] enable_next;
  logic [NUM_REGS-1:0] decode;
  logic [DATA_W-1:0]   data_reg;
  logic [DATA_W-1:0]   data_next;
  logic [ADDR_W-1:0]   resp_addr_reg;
  logic [ADDR_W-1:0]   resp_addr_next;

  // Register 0 never drives the bus, so its enable bit is tied low at the source.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
      if (gi == 0) begin : g_zero
        assign decode[gi] = 1'b0;
      end else begin : g_reg
        assign decode[gi] = (req_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      enable_reg    <= '0;
      data_reg      <= '0;
      resp_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      enable_reg    <= enable_next;
      data_reg      <= data_next;
      resp_addr_reg <= resp_addr_next;
    end
  end

  // Enables are registered so the tristate drivers see a glitch-free vector
  // that is high for exactly the DRIVE cycle.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    enable_next    = '0;
    data_next      = data_reg;
    resp_addr_next = resp_addr_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          addr_next   = req_addr;
          enable_next = decode;
          state_next  = DRIVE;
        end
      end
      DRIVE: begin
        if (addr_reg == '0) begin
          data_next = '0;
        end else if (wr_en && (wr_addr == addr_reg)) begin
          // The register still presents its old value during a same-cycle write.
          data_next = wr_data;
        end else begin
          data_next = bus_data;
        end
        resp_addr_next = addr_reg;
        state_next     = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req_ready   = (state_reg == IDLE);
  assign resp_valid  = (state_reg == RESP);
  assign read_enable = enable_reg;
  assign resp_data   = data_reg;
  assign resp_addr   = resp_addr_reg;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: models the register file behind the tristate bus
// and checks table, random and hand-written read sequences.
module tb_regfile_read_port;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam logic [DATA_W-1:0] FLOAT_VAL = 32'hBAD0_BAD0;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr = '0;
  logic [NUM_REGS-1:0] read_enable;
  logic [DATA_W-1:0]   bus_data;
  logic                wr_en = 1'b0;
  logic [ADDR_W-1:0]   wr_addr = '0;
  logic [DATA_W-1:0]   wr_data = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [DATA_W-1:0]   resp_data;
  logic [ADDR_W-1:0]   resp_addr;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_regs [NUM_REGS];

  regfile_read_port #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .read_enable(read_enable),
    .bus_data   (bus_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr)
  );

  always #5 clock = ~clock;

  // Registers drive the shared bus only when enabled; otherwise it floats.
  always_comb begin
    bus_data = FLOAT_VAL;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (read_enable[i]) bus_data = model_regs[i];
    end
  end

  always @(negedge clock) begin
    checks++;
    if (!$onehot0(read_enable) || read_enable[0]) begin
      errors++;
      $display("FAIL bus_contention: read_enable=%h required at most one bit and never bit 0", read_enable);
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a, input logic wen,
                                                 input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    if (a == 0) return '0;
    if (wen && wa == a) return wd;
    return model_regs[a];
  endfunction

  function automatic logic [NUM_REGS-1:0] ref_enable(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] e;
    e = '0;
    if (a != 0) e[a] = 1'b1;
    return e;
  endfunction

  task automatic do_read(input string name, input logic [ADDR_W-1:0] a, input logic wen,
                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input int stall, input logic [DATA_W-1:0] exp_data);
    int w;
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = a;
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clock);
      w++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL %s_timeout: req_ready stayed low for %0d cycles", name, w);
      req_valid = 1'b0;
      return;
    end
    @(negedge clock);
    req_valid = 1'b0;
    req_addr  = ADDR_W'($urandom);
    check({name, "_drive_en"}, read_enable, ref_enable(a));
    check({name, "_drive_ready"}, 32'(req_ready), 32'd0);
    check({name, "_drive_valid"}, 32'(resp_valid), 32'd0);
    wr_en   = wen;
    wr_addr = wa;
    wr_data = wd;
    @(negedge clock);
    wr_en = 1'b0;
    check({name, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({name, "_resp_data"}, resp_data, exp_data);
    check({name, "_resp_addr"}, 32'(resp_addr), 32'(a));
    check({name, "_resp_en"}, read_enable, '0);
    for (int s = 0; s < stall; s++) begin
      wr_en     = 1'b1;
      wr_addr   = a;
      wr_data   = ~exp_data;
      req_valid = 1'b1;
      @(negedge clock);
      check({name, "_stall_valid"}, 32'(resp_valid), 32'd1);
      check({name, "_stall_data"}, resp_data, exp_data);
      check({name, "_stall_addr"}, 32'(resp_addr), 32'(a));
      check({name, "_stall_en"}, read_enable, '0);
      check({name, "_stall_ready"}, 32'(req_ready), 32'd0);
    end
    wr_en      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check({name, "_done_valid"}, 32'(resp_valid), 32'd0);
    check({name, "_done_ready"}, 32'(req_ready), 32'd1);
    check({name, "_done_data"}, resp_data, exp_data);
    $display("read %s addr=%0d data=%h stall=%0d", name, a, resp_data, stall);
  endtask

  task automatic reset_mid(input string name, input bit in_resp);
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = 5'd12;
    @(negedge clock);
    req_valid = 1'b0;
    check({name, "_en12"}, read_enable, ref_enable(5'd12));
    if (in_resp) begin
      @(negedge clock);
      check({name, "_in_resp"}, 32'(resp_valid), 32'd1);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check({name, "_rst_en"}, read_enable, '0);
    check({name, "_rst_valid"}, 32'(resp_valid), 32'd0);
    check({name, "_rst_data"}, resp_data, '0);
    check({name, "_rst_ready"}, 32'(req_ready), 32'd1);
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check({name, "_no_resp"}, 32'(resp_valid), 32'd0);
    end
    resp_ready = 1'b0;
    $display("reset %s in_resp=%0d", name, in_resp);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    int                stall;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  initial begin
    vec_t vecs [8];
    logic [ADDR_W-1:0] b2b_addr [3];
    logic [DATA_W-1:0] b2b_exp [3];
    int sent;
    int got;

    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = $urandom;
    model_regs[5]  = 32'hDEAD_BEEF;
    model_regs[7]  = 32'h1111_1111;
    model_regs[12] = 32'h0C0C_0C0C;
    model_regs[31] = 32'hA5A5_0031;

    vecs[0] = '{5'd5,  1'b0, 5'd0,  32'h0,         0, 32'hDEAD_BEEF};
    vecs[1] = '{5'd0,  1'b0, 5'd0,  32'h0,         0, 32'h0};
    vecs[2] = '{5'd7,  1'b1, 5'd7,  32'h2222_2222, 0, 32'h2222_2222};
    vecs[3] = '{5'd7,  1'b1, 5'd8,  32'h2222_2222, 0, 32'h1111_1111};
    vecs[4] = '{5'd5,  1'b0, 5'd0,  32'h0,         5, 32'hDEAD_BEEF};
    vecs[5] = '{5'd31, 1'b1, 5'd0,  32'hFFFF_FFFF, 1, 32'hA5A5_0031};
    vecs[6] = '{5'd0,  1'b1, 5'd0,  32'hFFFF_FFFF, 2, 32'h0};
    vecs[7] = '{5'd1,  1'b1, 5'd1,  32'h0000_0000, 0, 32'h0};

    repeat (3) @(negedge clock);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_en", read_enable, '0);
    reset = 1'b0;
    @(negedge clock);
    check("init_ready", 32'(req_ready), 32'd1);
    check("init_en", read_enable, '0);
    check("init_valid", 32'(resp_valid), 32'd0);
    check("init_data", resp_data, '0);
    check("init_addr", 32'(resp_addr), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wen, vecs[i].waddr,
              vecs[i].wdata, vecs[i].stall, vecs[i].exp_data);
    end

    for (int i = 0; i < 40; i++) begin
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] wa;
      logic              wen;
      logic [DATA_W-1:0] wd;
      model_regs[$urandom_range(1, NUM_REGS - 1)] = $urandom;
      a   = ADDR_W'($urandom);
      wen = 1'($urandom);
      wa  = ($urandom_range(0, 1) == 1) ? a : ADDR_W'($urandom);
      wd  = $urandom;
      do_read($sformatf("rnd%0d", i), a, wen, wa, wd, $urandom_range(0, 3), ref_read(a, wen, wa, wd));
    end

    reset_mid("rst_drive", 1'b0);
    reset_mid("rst_resp", 1'b1);

    b2b_addr[0] = 5'd1;
    b2b_addr[1] = 5'd31;
    b2b_addr[2] = 5'd16;
    for (int i = 0; i < 3; i++) b2b_exp[i] = model_regs[b2b_addr[i]];
    sent = 0;
    got  = 0;
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge clock);
      if (resp_valid) begin
        check("b2b_ready_low", 32'(req_ready), 32'd0);
        check($sformatf("b2b%0d_data", got), resp_data, b2b_exp[got]);
        check($sformatf("b2b%0d_addr", got), 32'(resp_addr), 32'(b2b_addr[got]));
        $display("b2b resp %0d addr=%0d data=%h", got, resp_addr, resp_data);
        got++;
      end
      req_valid = (sent < 3);
      if (sent < 3) begin
        req_addr = b2b_addr[sent];
        if (req_ready) sent++;
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check("b2b_count", 32'(got), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read-side controller for the 32-entry register file.
- Each register drives a shared 32-bit tristate bus when its out_enable bit is high. This block turns a read request into a one-hot enable vector, samples the bus and returns the data over a valid/ready handshake.
- It also handles register 0 (reads as zero) and write-to-read bypass, so the decode pipeline sees coherent values.

Parameters:
- NUM_REGS, 32, number of registers on the bus; also the width of read_enable.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W = NUM_REGS.
- DATA_W, 32, data bus width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  read request present
- req_ready  output  1  block can accept a request
- req_addr  input  ADDR_W  register to read
- read_enable  output  NUM_REGS  one-hot out_enable vector to the registers; at most one bit high
- bus_data  input  DATA_W  shared tristate read bus
- wr_en  input  1  regfile write occurring this cycle (used for bypass)
- wr_addr  input  ADDR_W  regfile write address
- wr_data  input  DATA_W  regfile write data
- resp_valid  output  1  response data valid
- resp_ready  input  1  consumer accepts response
- resp_data  output  DATA_W  read result
- resp_addr  output  ADDR_W  address the response belongs to

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, on ports clock and reset.
- FSM states: IDLE, DRIVE, RESP. Reset forces IDLE.
- Reset values: req_ready=1, read_enable=0, resp_valid=0, resp_data=0, resp_addr=0.
- IDLE:
  - req_ready=1, read_enable=0.
  - On req_valid && req_ready, latch req_addr into addr_q and go to DRIVE.
- DRIVE (exactly one cycle):
  - req_ready=0.
  - read_enable = one-hot(addr_q) if addr_q != 0; otherwise all zeros.
  - At the closing edge, load resp_data by priority:
    - addr_q==0 -> 0.
    - wr_en && wr_addr==addr_q -> wr_data (bypass, because the register still shows its old value this cycle).
    - otherwise -> bus_data.
  - At the same edge, load resp_addr=addr_q, set resp_valid=1 and go to RESP.
- RESP:
  - read_enable=0, req_ready=0.
  - resp_valid, resp_data and resp_addr held stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid=0 next cycle, go to IDLE. resp_data keeps its last value.
- Latency: request accepted at edge N. DRIVE is cycle N..N+1, resp_valid is high after edge N+1. Minimum 3 cycles per read including the return to IDLE.
- Bus contention rule:
  - read_enable is zero in every state except DRIVE.
  - It never has more than one bit set, and is never nonzero for addr 0.
  - This must hold in all cases, including reset.
- Writes in RESP or IDLE do not update an already-captured resp_data. The consumer owns hazards after capture.
- Reset mid-operation (DRIVE or RESP): next cycle IDLE with all reset values. A pending response is dropped, and read_enable goes to 0 at that edge.
- req_valid while not in IDLE: ignored; the requester must hold it until req_ready.
- Simultaneous resp_ready and a new req_valid in RESP: the new request is not accepted that cycle; it is accepted in the following IDLE cycle.
- Out-of-range addresses cannot occur (2^ADDR_W = NUM_REGS).

Test Plan:
- Basic read:
  - Stimulus: after reset, req addr=5; model register 5 drives bus 32'hDEADBEEF when read_enable[5]; resp_ready=1.
  - Required: read_enable=32'h0000_0020 for exactly one cycle; resp_valid next with resp_data=32'hDEADBEEF and resp_addr=5; req_ready returns high one cycle after the handshake.
- Register zero:
  - Stimulus: req addr=0 with bus floating/X.
  - Required: read_enable stays 0 throughout; resp_data=0.
- Bypass:
  - Stimulus: req addr=7 with bus=32'h1111_1111; wr_en=1, wr_addr=7, wr_data=32'h2222_2222 during DRIVE.
  - Required: resp_data=32'h2222_2222.
  - Repeat with wr_addr=8: resp_data=32'h1111_1111.
- Backpressure:
  - Stimulus: resp_ready=0 for 5 cycles after resp_valid.
  - Required: resp_valid, resp_data and resp_addr stable; req_ready=0; read_enable=0; completes on the first cycle resp_ready=1.
- Reset mid-read:
  - Stimulus: assert reset in DRIVE for addr 12, and separately in RESP.
  - Required: the next cycle shows read_enable=0, resp_valid=0, resp_data=0 and req_ready=1; no response is delivered.
- Back-to-back:
  - Stimulus: reads of addrs 1, 31 and 16 with req_valid held high and resp_ready=1.
  - Required: one response each, in order, with correct data; read_enable never has more than one bit set (checked by an assertion every cycle).
